conv_weight_sched: RTL and testbench

//  Sequencer for one conv-layer pass. Drives the stage code for the weight cache and PE array
//  (INIT/PRELOAD/SHIFT/LOAD), generates the weight ROM address, and selects the weight set.

---
 rtl/conv_weight_sched.sv | 139 +++++++++++++
 tb/tb_conv_weight_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_sched.sv
// Conv-layer pass sequencer: walks PRELOAD/SHIFT/LOAD per output row and emits the
// weight ROM address for the latched weight set, with hold, abort and start/done handshake.
module conv_weight_sched #(
   parameter int unsigned KERNEL_SIZE    = 3,
   parameter int unsigned IMAGE_SIZE     = 8,
   parameter int unsigned ARRAY_SIZE     = 6,
   parameter int unsigned WEIGHT_SET_NUM = 2,
   parameter int unsigned SET_STRIDE     = 16,
   parameter int unsigned ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_weight_set,
   input  logic              i_hold,
   input  logic              i_abort,
   output logic [2:0]        o_state,
   output logic [ADDR_W-1:0] o_weight_addr,
   output logic              o_weight_vld,
   output logic [2:0]        o_row_idx,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned KW = (KK > 1) ? $clog2(KK) : 1;
   localparam int unsigned PW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

   localparam logic [KW-1:0] LastK   = KW'(KK - 1);
   localparam logic [PW-1:0] LastPre = PW'(KERNEL_SIZE - 1);
   localparam logic [2:0]    LastRow = 3'(ARRAY_SIZE - 1);

   // Geometry and ROM layout must be consistent or the pass silently misaddresses.
   if (IMAGE_SIZE != ARRAY_SIZE + KERNEL_SIZE - 1) begin : g_bad_geometry
      $error("IMAGE_SIZE must equal ARRAY_SIZE+KERNEL_SIZE-1");
   end
   if ((WEIGHT_SET_NUM - 1) * SET_STRIDE + KK - 1 >= (1 << ADDR_W)) begin : g_bad_addr
      $error("weight ROM layout does not fit ADDR_W");
   end

   typedef enum logic [2:0] {
      StInit    = 3'd0,
      StPreload = 3'd1,
      StShift   = 3'd2,
      StLoad    = 3'd3
   } state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    row_q, row_d;
   logic          set_q, set_d;
   logic          done_q, done_d;
   logic          active;

   assign active = (state_q == StPreload) || (state_q == StShift) || (state_q == StLoad);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pre_d   = pre_q;
      row_d   = row_q;
      set_d   = set_q;
      done_d  = 1'b0;
      if (active && i_abort) begin
         state_d = StInit;
         k_d     = '0;
         pre_d   = '0;
         row_d   = '0;
      end else if (active && i_hold) begin
         // everything frozen
      end else begin
         case (state_q)
            StInit: begin
               if (i_start && !i_abort) begin
                  set_d   = i_weight_set;
                  pre_d   = '0;
                  row_d   = '0;
                  k_d     = '0;
                  state_d = StPreload;
               end
            end
            StPreload: begin
               if (pre_q == LastPre) begin
                  state_d = StShift;
                  k_d     = '0;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
            StShift: begin
               if (k_q == LastK) begin
                  state_d = StLoad;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            StLoad: begin
               if (row_q == LastRow) begin
                  state_d = StInit;
                  row_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  row_d   = row_q + 1'b1;
                  k_d     = '0;
                  state_d = StShift;
               end
            end
            default: state_d = StInit;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StInit;
         k_q     <= '0;
         pre_q   <= '0;
         row_q   <= '0;
         set_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pre_q   <= pre_d;
         row_q   <= row_d;
         set_q   <= set_d;
         done_q  <= done_d;
      end
   end

   assign o_state       = state_q;
   assign o_weight_addr = (ADDR_W'(set_q) * ADDR_W'(SET_STRIDE)) + ADDR_W'(k_q);
   assign o_weight_vld  = (state_q == StShift) && !i_hold;
   assign o_row_idx     = row_q;
   assign o_busy        = (state_q != StInit);
   assign o_done        = done_q;

endmodule

// File: tb/tb_conv_weight_sched.sv
// Directed bench for conv_weight_sched: full passes on both weight sets, hold, abort,
// ignored start, start+abort in INIT and mid-pass reset.
module tb_conv_weight_sched;

   logic       clk = 1'b0;
   logic       rst_n, i_start, i_weight_set, i_hold, i_abort;
   logic [2:0] o_state;
   logic [4:0] o_weight_addr;
   logic       o_weight_vld;
   logic [2:0] o_row_idx;
   logic       o_busy, o_done;

   int n_cmp = 0;
   int n_fail = 0;

   conv_weight_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_weight_set (i_weight_set),
      .i_hold       (i_hold),
      .i_abort      (i_abort),
      .o_state      (o_state),
      .o_weight_addr(o_weight_addr),
      .o_weight_vld (o_weight_vld),
      .o_row_idx    (o_row_idx),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_start = 1'b0; i_weight_set = 1'b0; i_hold = 1'b0; i_abort = 1'b0;
      step(); step();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++;
         if ({o_state, o_busy, o_done, o_weight_addr} !== {3'd0, 1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d: state=%0d busy=%0b done=%0b addr=%0d, want 0/0/0/0",
                     c, o_state, o_busy, o_done, o_weight_addr);
         end
      end
   endtask

   // Runs one pass from INIT, optionally holding at row hold_row k=5 for 4 cycles,
   // flipping the set input mid-pass, or aborting at the LOAD of abort_row.
   task automatic run_pass(input logic set, input bit flip, input int hold_row,
                           input int abort_row);
      int         e;
      logic [4:0] base;
      base = set ? 5'd16 : 5'd0;
      i_weight_set = set;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      e = 0;
      for (int p = 0; p < 3; p++) begin
         n_cmp++;
         if ({o_state, o_busy, o_done} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL preload p=%0d: state=%0d busy=%0b done=%0b, want 1/1/0",
                     p, o_state, o_busy, o_done);
         end
         step(); e++;
      end
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 9; k++) begin
            if (flip && r == 2 && k == 0) i_weight_set = ~set;
            if (r == hold_row && k == 5) begin
               for (int h = 0; h < 4; h++) begin
                  i_hold = 1'b1;
                  #1;
                  n_cmp++;
                  if ({o_state, o_weight_addr, o_weight_vld} !== {3'd2, base + 5'(k), 1'b0}) begin
                     n_fail++;
                     $display("FAIL hold h=%0d: state=%0d addr=%0d vld=%0b, want 2/%0d/0",
                              h, o_state, o_weight_addr, o_weight_vld, base + 5'(k));
                  end
                  step(); e++;
               end
               i_hold = 1'b0;
               #1;
            end
            n_cmp++;
            if ({o_state, o_weight_addr, o_weight_vld, o_row_idx, o_done} !==
                {3'd2, base + 5'(k), 1'b1, 3'(r), 1'b0}) begin
               n_fail++;
               $display("FAIL shift r=%0d k=%0d: state=%0d addr=%0d vld=%0b row=%0d done=%0b, want 2/%0d/1/%0d/0",
                        r, k, o_state, o_weight_addr, o_weight_vld, o_row_idx, o_done,
                        base + 5'(k), r);
            end
            step(); e++;
         end
         n_cmp++;
         if ({o_state, o_row_idx, o_weight_vld, o_done} !== {3'd3, 3'(r), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load r=%0d: state=%0d row=%0d vld=%0b done=%0b, want 3/%0d/0/0",
                     r, o_state, o_row_idx, o_weight_vld, o_done, r);
         end
         if (r == abort_row) begin
            i_abort = 1'b1;
            step();
            i_abort = 1'b0;
            n_cmp++;
            if ({o_state, o_busy, o_done, o_row_idx} !== {3'd0, 1'b0, 1'b0, 3'd0}) begin
               n_fail++;
               $display("FAIL abort: state=%0d busy=%0b done=%0b row=%0d, want 0/0/0/0",
                        o_state, o_busy, o_done, o_row_idx);
            end
            for (int c = 0; c < 10; c++) begin
               step();
               n_cmp++;
               if ({o_state, o_done} !== {3'd0, 1'b0}) begin
                  n_fail++;
                  $display("FAIL abort_idle c=%0d: state=%0d done=%0b, want 0/0",
                           c, o_state, o_done);
               end
            end
            i_weight_set = 1'b0;
            return;
         end
         step(); e++;
      end
      n_cmp++;
      if ({o_state, o_busy, o_done, o_row_idx} !== {3'd0, 1'b0, 1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL done: state=%0d busy=%0b done=%0b row=%0d, want 0/0/1/0",
                  o_state, o_busy, o_done, o_row_idx);
      end
      n_cmp++;
      if (e !== ((hold_row >= 0) ? 67 : 63)) begin
         n_fail++;
         $display("FAIL done_edge: got %0d, want %0d", e, (hold_row >= 0) ? 67 : 63);
      end
      step();
      n_cmp++;
      if ({o_state, o_done} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL done_pulse: state=%0d done=%0b, want 0/0", o_state, o_done);
      end
      i_weight_set = 1'b0;
   endtask

   task automatic test_pass_set0();
      run_pass(1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_pass_set1();
      run_pass(1'b1, 1'b1, -1, -1);
   endtask

   task automatic test_hold();
      run_pass(1'b0, 1'b0, 2, -1);
   endtask

   task automatic test_abort();
      run_pass(1'b0, 1'b0, -1, 3);
      run_pass(1'b1, 1'b0, -1, -1);
   endtask

   task automatic test_start_ignored();
      i_weight_set = 1'b0;
      i_start = 1'b1;
      step();
      for (int p = 0; p < 2; p++) begin
         step();
         n_cmp++;
         if (o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL busy_start p=%0d: state=%0d, want 1", p, o_state);
         end
      end
      i_weight_set = 1'b1;
      step();
      n_cmp++;
      if ({o_state, o_weight_addr} !== {3'd2, 5'd0}) begin
         n_fail++;
         $display("FAIL busy_start_shift: state=%0d addr=%0d, want 2/0", o_state, o_weight_addr);
      end
      i_start = 1'b0;
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      n_cmp++;
      if (o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL abort_shift: state=%0d, want 0", o_state);
      end
      i_start = 1'b1; i_abort = 1'b1;
      step();
      n_cmp++;
      if ({o_state, o_busy} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL start_abort: state=%0d busy=%0b, want 0/0", o_state, o_busy);
      end
      i_start = 1'b0; i_abort = 1'b0; i_weight_set = 1'b0;
      step();
      n_cmp++;
      if (o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL start_abort_after: state=%0d, want 0", o_state);
      end
   endtask

   task automatic test_reset_mid();
      i_weight_set = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 0; c < 6; c++) step();
      n_cmp++;
      if ({o_state, o_weight_addr} !== {3'd2, 5'd19}) begin
         n_fail++;
         $display("FAIL pre_reset: state=%0d addr=%0d, want 2/19", o_state, o_weight_addr);
      end
      rst_n = 1'b0;
      step();
      n_cmp++;
      if ({o_state, o_weight_addr, o_row_idx, o_busy, o_done} !==
          {3'd0, 5'd0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: state=%0d addr=%0d row=%0d busy=%0b done=%0b, want all 0",
                  o_state, o_weight_addr, o_row_idx, o_busy, o_done);
      end
      rst_n = 1'b1;
      i_weight_set = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_pass_set0();
      test_pass_set1();
      test_hold();
      test_abort();
      test_start_ignored();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
